axil_to_apb_bridge: RTL and testbench

//   AXI4-Lite slave to APB4 master bridge; front end of the I3C CSR path on AXI-based SoCs.

---
 rtl/axil_to_apb_bridge_if.sv | 64 ++++++
 rtl/axil_to_apb_bridge.sv | 165 ++++++++++++++++
 tb/tb_axil_to_apb_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_to_apb_bridge_if.sv
// rtl/axil_to_apb_bridge_if.sv - AXI4-Lite and APB4 bus bundles used by the bridge
// Signal names keep the bridge-side _i/_o direction suffixes so both ends read the same.

interface axil_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                     awvalid_i;
    logic                     awready_o;
    logic [AddrWidth-1:0]     awaddr_i;
    logic                     wvalid_i;
    logic                     wready_o;
    logic [DataWidth-1:0]     wdata_i;
    logic [DataWidth/8-1:0]   wstrb_i;
    logic                     bvalid_o;
    logic                     bready_i;
    logic [1:0]               bresp_o;
    logic                     arvalid_i;
    logic                     arready_o;
    logic [AddrWidth-1:0]     araddr_i;
    logic                     rvalid_o;
    logic                     rready_i;
    logic [DataWidth-1:0]     rdata_o;
    logic [1:0]               rresp_o;

    modport slave (
        input  awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
               arvalid_i, araddr_i, rready_i,
        output awready_o, wready_o, bvalid_o, bresp_o, arready_o,
               rvalid_o, rdata_o, rresp_o
    );

    modport master (
        output awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
               arvalid_i, araddr_i, rready_i,
        input  awready_o, wready_o, bvalid_o, bresp_o, arready_o,
               rvalid_o, rdata_o, rresp_o
    );
endinterface

interface apb_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                     psel_o;
    logic                     penable_o;
    logic                     pwrite_o;
    logic [AddrWidth-1:0]     paddr_o;
    logic [DataWidth-1:0]     pwdata_o;
    logic [DataWidth/8-1:0]   pstrb_o;
    logic [DataWidth-1:0]     prdata_i;
    logic                     pready_i;
    logic                     pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/axil_to_apb_bridge.sv
// rtl/axil_to_apb_bridge.sv - AXI4-Lite slave to APB4 master bridge with ACCESS watchdog
// One transaction in flight; hung APB transfers are answered with SLVERR.

module axil_to_apb_bridge #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    axil_if.slave io_axil,
    apb_if.master io_apb
);
    if (DataWidth != 32) begin : g_bad_data_width
        $error("axil_to_apb_bridge: DataWidth must be 32");
    end
    if (AddrWidth < 10 || AddrWidth > 64) begin : g_bad_addr_width
        $error("axil_to_apb_bridge: AddrWidth must be within 10..64");
    end

    localparam int StrbWidth = DataWidth / 8;
    localparam int WdWidth   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [WdWidth-1:0]   WdLast   = WdWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(3);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                 r_state;
    logic                   r_prio_wr;
    logic                   r_dir_wr;
    logic [WdWidth-1:0]     r_wdog;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [AddrWidth-1:0]   r_paddr;
    logic [DataWidth-1:0]   r_pwdata;
    logic [StrbWidth-1:0]   r_pstrb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [DataWidth-1:0]   r_rdata;
    logic [1:0]             r_rresp;

    logic w_idle;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_take_wr;
    logic w_take_rd;
    logic w_timeout;
    logic w_done;

    // Gating with rst_ni keeps the ready outputs at 0 while reset is held.
    assign w_idle    = rst_ni && (r_state == IDLE);
    assign w_wr_elig = w_idle && io_axil.awvalid_i && io_axil.wvalid_i;
    assign w_rd_elig = w_idle && io_axil.arvalid_i;
    assign w_take_wr = w_wr_elig && (!w_rd_elig || r_prio_wr);
    assign w_take_rd = w_rd_elig && !w_take_wr;
    assign w_timeout = (TimeoutCycles > 0) && (r_wdog == WdLast);
    assign w_done    = io_apb.pready_i || w_timeout;

    assign io_axil.awready_o = w_take_wr;
    assign io_axil.wready_o  = w_take_wr;
    assign io_axil.arready_o = w_take_rd;
    assign io_axil.bvalid_o  = r_bvalid;
    assign io_axil.bresp_o   = r_bresp;
    assign io_axil.rvalid_o  = r_rvalid;
    assign io_axil.rdata_o   = r_rdata;
    assign io_axil.rresp_o   = r_rresp;

    assign io_apb.psel_o    = r_psel;
    assign io_apb.penable_o = r_penable;
    assign io_apb.pwrite_o  = r_pwrite;
    assign io_apb.paddr_o   = r_paddr;
    assign io_apb.pwdata_o  = r_pwdata;
    assign io_apb.pstrb_o   = r_pstrb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_prio_wr <= 1'b1;
            r_dir_wr  <= 1'b0;
            r_wdog    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RespOkay;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RespOkay;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take_wr) begin
                        r_state  <= SETUP;
                        r_dir_wr <= 1'b1;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                        r_paddr  <= io_axil.awaddr_i & AddrMask;
                        r_pwdata <= io_axil.wdata_i;
                        r_pstrb  <= io_axil.wstrb_i;
                        if (w_rd_elig) r_prio_wr <= ~r_prio_wr;
                    end else if (w_take_rd) begin
                        r_state  <= SETUP;
                        r_dir_wr <= 1'b0;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b0;
                        r_paddr  <= io_axil.araddr_i & AddrMask;
                        r_pwdata <= '0;
                        r_pstrb  <= '0;
                        if (w_wr_elig) r_prio_wr <= ~r_prio_wr;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                    r_wdog    <= '0;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_state   <= RESP;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        r_pstrb   <= '0;
                        // A completed transfer wins over a watchdog expiring in the same cycle.
                        if (r_dir_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (!io_apb.pready_i || io_apb.pslverr_i) ? RespSlverr : RespOkay;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= io_apb.pready_i ? io_apb.prdata_i : '0;
                            r_rresp  <= (!io_apb.pready_i || io_apb.pslverr_i) ? RespSlverr : RespOkay;
                        end
                    end else if (TimeoutCycles > 0) begin
                        r_wdog <= r_wdog + WdWidth'(1);
                    end
                end
                RESP: begin
                    if ((r_bvalid && io_axil.bready_i) || (r_rvalid && io_axil.rready_i)) begin
                        r_state  <= IDLE;
                        r_bvalid <= 1'b0;
                        r_bresp  <= RespOkay;
                        r_rvalid <= 1'b0;
                        r_rdata  <= '0;
                        r_rresp  <= RespOkay;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_to_apb_bridge.sv
// tb/tb_axil_to_apb_bridge.sv - directed self-checking bench for axil_to_apb_bridge

module tb_axil_to_apb_bridge;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    axil_if #(.AddrWidth(32), .DataWidth(32)) axil ();
    apb_if  #(.AddrWidth(32), .DataWidth(32)) apb ();

    axil_to_apb_bridge #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .io_axil(axil),
        .io_apb (apb)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " axi ready"}, {axil.awready_o, axil.wready_o, axil.arready_o}, 3'b000);
        chk({tag, " axi resp"}, {axil.bvalid_o, axil.bresp_o, axil.rvalid_o, axil.rresp_o}, 6'd0);
        chk({tag, " rdata"}, axil.rdata_o, 32'h0);
        chk({tag, " apb ctl"}, {apb.psel_o, apb.penable_o, apb.pwrite_o, apb.pstrb_o}, 7'd0);
        chk({tag, " apb addr/data"}, {apb.paddr_o, apb.pwdata_o}, 64'd0);
    endtask

    // Present requests, check which one the bridge selects, then drop the accepted ones.
    task automatic req(input string tag, input bit aw, input bit ar,
                       input logic [31:0] waddr, input logic [31:0] raddr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input bit exp_wr, input bit exp_rd);
        axil.awvalid_i = aw;
        axil.wvalid_i  = aw;
        axil.arvalid_i = ar;
        if (aw) begin
            axil.awaddr_i = waddr;
            axil.wdata_i  = wd;
            axil.wstrb_i  = st;
        end
        if (ar) axil.araddr_i = raddr;
        settle();
        chk({tag, " aw/w/ar ready"}, {axil.awready_o, axil.wready_o, axil.arready_o},
            {exp_wr, exp_wr, exp_rd});
        step();
        if (exp_wr) begin
            axil.awvalid_i = 1'b0;
            axil.wvalid_i  = 1'b0;
        end
        if (exp_rd) axil.arvalid_i = 1'b0;
    endtask

    // Runs SETUP, ACCESS (with waits), RESP (with hold) and ends in the following IDLE cycle.
    task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input int waits,
                        input logic [31:0] rd, input bit err, input int hold);
        logic [1:0] exp_resp;
        exp_resp = err ? 2'b10 : 2'b00;
        settle();
        chk({tag, " setup sel/en"}, {apb.psel_o, apb.penable_o}, 2'b10);
        chk({tag, " paddr"}, apb.paddr_o, addr);
        chk({tag, " pwrite"}, apb.pwrite_o, wr);
        chk({tag, " pwdata"}, apb.pwdata_o, wd);
        chk({tag, " pstrb"}, apb.pstrb_o, st);
        step();
        apb.pready_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            settle();
            chk({tag, " wait sel/en"}, {apb.psel_o, apb.penable_o}, 2'b11);
            chk({tag, " wait pstrb"}, apb.pstrb_o, st);
            step();
        end
        apb.pready_i  = 1'b1;
        apb.prdata_i  = rd;
        apb.pslverr_i = err;
        settle();
        chk({tag, " access sel/en"}, {apb.psel_o, apb.penable_o}, 2'b11);
        step();
        apb.pready_i  = 1'b0;
        apb.pslverr_i = 1'b0;
        apb.prdata_i  = 32'h0BAD_F00D;
        for (int i = 0; i < hold; i++) begin
            settle();
            chk({tag, " hold valid"}, wr ? axil.bvalid_o : axil.rvalid_o, 1'b1);
            chk({tag, " hold resp"}, wr ? axil.bresp_o : axil.rresp_o, exp_resp);
            chk({tag, " hold no accept"}, {axil.awready_o, axil.wready_o, axil.arready_o}, 3'b000);
            step();
        end
        axil.bready_i = wr;
        axil.rready_i = !wr;
        settle();
        chk({tag, " valid"}, wr ? axil.bvalid_o : axil.rvalid_o, 1'b1);
        chk({tag, " resp"}, wr ? axil.bresp_o : axil.rresp_o, exp_resp);
        if (!wr) chk({tag, " rdata"}, axil.rdata_o, rd);
        chk({tag, " apb idle"}, {apb.psel_o, apb.penable_o, apb.pstrb_o}, 6'd0);
        step();
        axil.bready_i = 1'b0;
        axil.rready_i = 1'b0;
        settle();
        chk({tag, " valid cleared"}, {axil.bvalid_o, axil.rvalid_o}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        axil.awvalid_i = 1'b0; axil.awaddr_i = '0; axil.wvalid_i = 1'b0;
        axil.wdata_i   = '0;   axil.wstrb_i  = '0; axil.bready_i = 1'b0;
        axil.arvalid_i = 1'b0; axil.araddr_i = '0; axil.rready_i = 1'b0;
        apb.prdata_i   = '0;   apb.pready_i  = 1'b0; apb.pslverr_i = 1'b0;

        #12;
        chk_all_zero("reset held");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        settle();
        chk_all_zero("after reset");
        step();

        // Test 1: write, zero-wait completion, bvalid in cycle 3
        req("t1 accept", 1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A5_1234, 4'hF, 1'b1, 1'b0);
        xfer("t1", 1'b1, 32'h100, 32'hA5A5_1234, 4'hF, 0, 32'h0, 1'b0, 0);
        step();

        // Test 2: read with three wait states
        req("t2 accept", 1'b0, 1'b1, 32'h0, 32'h104, 32'h0, 4'h0, 1'b0, 1'b1);
        xfer("t2", 1'b0, 32'h104, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0, 0);
        step();

        // Test 3: ties alternate (write first after reset), low address bits masked
        req("t3 tie1", 1'b1, 1'b1, 32'h10B, 32'h20, 32'h1111_2222, 4'h3, 1'b1, 1'b0);
        xfer("t3 w1", 1'b1, 32'h108, 32'h1111_2222, 4'h3, 0, 32'h0, 1'b0, 0);
        req("t3 pend rd", 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1);
        xfer("t3 r1", 1'b0, 32'h20, 32'h0, 4'h0, 1, 32'h0000_00C3, 1'b0, 0);
        step();
        req("t3 tie2", 1'b1, 1'b1, 32'h30, 32'h46, 32'h3333_4444, 4'hC, 1'b0, 1'b1);
        xfer("t3 r2", 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h5A5A_0001, 1'b0, 0);
        req("t3 pend wr", 1'b1, 1'b0, 32'h30, 32'h0, 32'h3333_4444, 4'hC, 1'b1, 1'b0);
        xfer("t3 w2", 1'b1, 32'h30, 32'h3333_4444, 4'hC, 0, 32'h0, 1'b0, 0);
        step();

        // Test 4: write SLVERR held for 5 cycles with a read waiting behind it
        req("t4 accept", 1'b1, 1'b0, 32'h200, 32'h0, 32'h0000_BEEF, 4'h1, 1'b1, 1'b0);
        axil.arvalid_i = 1'b1;
        axil.araddr_i  = 32'h208;
        xfer("t4", 1'b1, 32'h200, 32'h0000_BEEF, 4'h1, 0, 32'h0, 1'b1, 5);
        req("t4 next rd", 1'b0, 1'b1, 32'h0, 32'h208, 32'h0, 4'h0, 1'b0, 1'b1);
        xfer("t4 rd", 1'b0, 32'h208, 32'h0, 4'h0, 0, 32'h7777_8888, 1'b0, 0);
        step();

        // Test 5: read never completes, watchdog aborts after 8 ACCESS cycles
        req("t5 accept", 1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b1);
        settle();
        chk("t5 setup sel/en", {apb.psel_o, apb.penable_o}, 2'b10);
        step();
        apb.pready_i = 1'b0;
        apb.prdata_i = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("t5 access sel/en", {apb.psel_o, apb.penable_o}, 2'b11);
            step();
        end
        settle();
        chk("t5 abort sel/en", {apb.psel_o, apb.penable_o}, 2'b00);
        chk("t5 rvalid", axil.rvalid_o, 1'b1);
        chk("t5 rresp", axil.rresp_o, 2'b10);
        chk("t5 rdata", axil.rdata_o, 32'h0);
        axil.rready_i = 1'b1;
        step();
        axil.rready_i = 1'b0;
        settle();
        chk("t5 rvalid cleared", axil.rvalid_o, 1'b0);
        step();

        // Test 6: asynchronous reset during ACCESS, then a clean write
        req("t6 accept", 1'b1, 1'b0, 32'h400, 32'h0, 32'hCAFE_0001, 4'hF, 1'b1, 1'b0);
        step();
        settle();
        chk("t6 access sel/en", {apb.psel_o, apb.penable_o}, 2'b11);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("t6 async reset");
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        step();
        settle();
        chk("t6 no stale resp", {axil.bvalid_o, axil.rvalid_o, apb.psel_o}, 3'b000);
        req("t6 accept2", 1'b1, 1'b0, 32'h404, 32'h0, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b0);
        xfer("t6 w", 1'b1, 32'h404, 32'h0BAD_CAFE, 4'hF, 0, 32'h0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
